reset_sequencer: RTL and testbench

Generates the CPU reset for the SoC core from PLL lock status and the external GRESET button. It replaces the free-running lock counter and the edge-detect synchroniser in front of the core's reset input. Both inputs are synchronised, the button is debounced, and a reset pulse of fixed minimum length is asserted after power-up, after PLL lock loss, and after each debounced button release. A saturating count of button resets and a last-cause code are exposed for GPIO readback.

---
 rtl/reset_sequencer.sv | 124 ++++++++++++
 tb/tb_reset_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// CPU reset generator: synchronises PLL lock and the GRESET button, debounces the
// button, and holds sys_reset for HOLD_CYCLES locked cycles after each trigger.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       button_in,
  output logic       sys_reset,
  output logic       button_state,
  output logic [1:0] reset_cause,
  output logic [7:0] button_resets
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] CAUSE_BLOCK  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK   = 2'b01;
  localparam logic [1:0] CAUSE_BUTTON = 2'b10;

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   deb_q, deb_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  state_t                 state_q, state_d;
  logic [1:0]             cause_q, cause_d;
  logic [7:0]             count_q, count_d;
  logic [7:0]             count_inc;
  logic                   lock_s, btn_s, btn_release;

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];

  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], button_in};

    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (btn_s == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_d     = btn_s;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end

    // Release is taken from the next-state value so the FSM reacts on the same edge.
    btn_release = deb_q & ~deb_d;
    count_inc   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    count_d    = count_q;

    case (state_q)
      HOLD: begin
        if (btn_release) begin
          hold_cnt_d = '0;
          cause_d    = CAUSE_BUTTON;
          count_d    = count_inc;
        end else if (!lock_s) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        // Lock loss wins over a simultaneous release and does not count it.
        if (!lock_s) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          cause_d    = CAUSE_LOCK;
        end else if (btn_release) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          cause_d    = CAUSE_BUTTON;
          count_d    = count_inc;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
      deb_cnt_q   <= '0;
      deb_q       <= 1'b0;
      hold_cnt_q  <= '0;
      state_q     <= HOLD;
      cause_q     <= CAUSE_BLOCK;
      count_q     <= 8'd0;
    end else begin
      lock_sync_q <= lock_sync_d;
      btn_sync_q  <= btn_sync_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_q       <= deb_d;
      hold_cnt_q  <= hold_cnt_d;
      state_q     <= state_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
    end
  end

  assign sys_reset     = (state_q == HOLD);
  assign button_state  = deb_q;
  assign reset_cause   = cause_q;
  assign button_resets = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with SYNC_STAGES=2, DEBOUNCE_CYCLES=16, HOLD_CYCLES=8.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       button_in;
  logic       sys_reset;
  logic       button_state;
  logic [1:0] reset_cause;
  logic [7:0] button_resets;

  int tests_run = 0;
  int tests_failed = 0;

  reset_sequencer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .button_in    (button_in),
    .sys_reset    (sys_reset),
    .button_state (button_state),
    .reset_cause  (reset_cause),
    .button_resets(button_resets)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b1;
    button_in  = 1'b0;
    tick(3);
    check_val("rst_sys_reset", 8'(sys_reset), 8'd1);
    check_val("rst_cause", 8'(reset_cause), 8'd0);
    check_val("rst_count", button_resets, 8'd0);
    check_val("rst_btn_state", 8'(button_state), 8'd0);

    // Power-up: sys_reset falls on edge 2+8.
    reset = 1'b0;
    tick(9);
    check_val("pwr_edge9", 8'(sys_reset), 8'd1);
    tick(1);
    check_val("pwr_edge10", 8'(sys_reset), 8'd0);
    check_val("pwr_cause", 8'(reset_cause), 8'd0);

    // Lock loss for 3 cycles while running.
    pll_locked = 1'b0;
    tick(2);
    check_val("lock_drop_e2", 8'(sys_reset), 8'd0);
    tick(1);
    check_val("lock_drop_e3", 8'(sys_reset), 8'd1);
    check_val("lock_cause", 8'(reset_cause), 8'd1);
    pll_locked = 1'b1;
    tick(9);
    check_val("lock_ret_e9", 8'(sys_reset), 8'd1);
    tick(1);
    check_val("lock_ret_e10", 8'(sys_reset), 8'd0);
    check_val("lock_count", button_resets, 8'd0);

    // 10-cycle glitch is filtered.
    button_in = 1'b1;
    tick(10);
    check_val("glitch_mid_state", 8'(button_state), 8'd0);
    button_in = 1'b0;
    tick(30);
    check_val("glitch_state", 8'(button_state), 8'd0);
    check_val("glitch_sys_reset", 8'(sys_reset), 8'd0);
    check_val("glitch_count", button_resets, 8'd0);

    // Full press/release.
    button_in = 1'b1;
    tick(17);
    check_val("press_e17", 8'(button_state), 8'd0);
    tick(1);
    check_val("press_e18", 8'(button_state), 8'd1);
    tick(22);
    check_val("press_no_reset", 8'(sys_reset), 8'd0);
    button_in = 1'b0;
    tick(17);
    check_val("rel_e17_sys", 8'(sys_reset), 8'd0);
    check_val("rel_e17_state", 8'(button_state), 8'd1);
    tick(1);
    check_val("rel_e18_sys", 8'(sys_reset), 8'd1);
    check_val("rel_e18_state", 8'(button_state), 8'd0);
    check_val("rel_cause", 8'(reset_cause), 8'd2);
    check_val("rel_count", button_resets, 8'd1);
    tick(7);
    check_val("rel_hold7", 8'(sys_reset), 8'd1);
    tick(1);
    check_val("rel_hold8", 8'(sys_reset), 8'd0);

    // Release lands in HOLD with hold_cnt=5: the hold restarts.
    button_in = 1'b1;
    tick(20);
    check_val("h5_pressed", 8'(button_state), 8'd1);
    pll_locked = 1'b0;
    tick(5);
    check_val("h5_lock_hold", 8'(sys_reset), 8'd1);
    button_in = 1'b0;
    tick(10);
    pll_locked = 1'b1;
    tick(7);
    check_val("h5_cause_before", 8'(reset_cause), 8'd1);
    tick(1);
    check_val("h5_cause", 8'(reset_cause), 8'd2);
    check_val("h5_count", button_resets, 8'd2);
    tick(2);
    check_val("h5_restart", 8'(sys_reset), 8'd1);
    tick(5);
    check_val("h5_hold7", 8'(sys_reset), 8'd1);
    tick(1);
    check_val("h5_hold8", 8'(sys_reset), 8'd0);

    // Lock loss on the same edge as a release in RUN.
    button_in = 1'b1;
    tick(20);
    check_val("tie_pressed", 8'(button_state), 8'd1);
    button_in = 1'b0;
    tick(15);
    pll_locked = 1'b0;
    tick(2);
    check_val("tie_pre", 8'(sys_reset), 8'd0);
    tick(1);
    check_val("tie_sys", 8'(sys_reset), 8'd1);
    check_val("tie_cause", 8'(reset_cause), 8'd1);
    check_val("tie_count", button_resets, 8'd2);
    check_val("tie_state", 8'(button_state), 8'd0);
    pll_locked = 1'b1;
    tick(10);
    check_val("tie_run", 8'(sys_reset), 8'd0);

    // Saturation over 300 press/release cycles.
    for (int i = 0; i < 300; i++) begin
      button_in = 1'b1;
      tick(20);
      button_in = 1'b0;
      tick(20);
      if (i == 99) check_val("sat_mid", button_resets, 8'd102);
    end
    check_val("sat_final", button_resets, 8'd255);

    // Block reset mid-HOLD with the button debounced high.
    button_in = 1'b1;
    tick(20);
    check_val("mid_pressed", 8'(button_state), 8'd1);
    pll_locked = 1'b0;
    tick(4);
    check_val("mid_hold", 8'(sys_reset), 8'd1);
    reset = 1'b1;
    tick(1);
    check_val("mid_sys", 8'(sys_reset), 8'd1);
    check_val("mid_state", 8'(button_state), 8'd0);
    check_val("mid_cause", 8'(reset_cause), 8'd0);
    check_val("mid_count", button_resets, 8'd0);

    reset      = 1'b0;
    pll_locked = 1'b1;
    button_in  = 1'b0;
    tick(9);
    check_val("re_pwr_e9", 8'(sys_reset), 8'd1);
    tick(1);
    check_val("re_pwr_e10", 8'(sys_reset), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
